cplx_result_avg: RTL and testbench
==================================

Name: cplx_result_avg

Overview:
- Consumer at the far end of the adder/subtractor result bus.
- Accepts packed complex result words, {real[31:16], imag[15:0]}, each half 16-bit two's complement, over a valid/ready handshake.
- Accumulates a frame of 2^LOG2_N words and emits the per-component average as one packed word over a second valid/ready handshake.
- Sits between the add/sub datapath and downstream display/logging logic.

Parameters:
- LOG2_N, 2, log2 of frame length; frame length N = 2^LOG2_N; legal range 1..8.
- ACC_W, 16+LOG2_N (derived, not overridable), accumulator width per component; wide enough that no overflow is possible.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_data  input  32  packed complex sample: [31:16] real, [15:0] imag.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data this cycle.
- clear  input  1  synchronous frame abort.
- out_data  output  32  packed average: [31:16] real, [15:0] imag.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- frame_cnt  output  LOG2_N  samples accepted in the current frame.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst sampled high on a clk edge forces state=S_ACC, acc_re=acc_im=0, frame_cnt=0, out_data=0, out_valid=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after rst falls.
  - Reset mid-frame or mid-output drops all partial sums and any pending output.
- FSM, two states:
  - S_ACC: in_ready=1, out_valid=0. Accept = in_valid & in_ready.
    - On accept: acc_re += sign-extended in_data[31:16]; acc_im += sign-extended in_data[15:0]; frame_cnt increments.
    - Accept with frame_cnt == N-1: register out_data = {(acc_re+x_re)>>>LOG2_N, (acc_im+x_im)>>>LOG2_N} truncated to 16 bits each. Same edge: clear acc, frame_cnt=0, go to S_OUT.
  - S_OUT: in_ready=0, out_valid=1.
    - out_data is held stable until out_valid & out_ready.
    - On the handshake: go to S_ACC, out_valid=0. in_ready is 1 the next cycle.
- Arithmetic:
  - Arithmetic right shift, i.e. floor rounding toward -inf; e.g. sum -1 gives -1, sum 1 gives 0.
  - Each average is always in 16-bit range; no saturation logic.
- Latency:
  - Last sample accepted on edge T means out_valid=1 in the cycle after T.
  - Max throughput: N+1 cycles per frame with out_ready tied high.
- Backpressure: in S_OUT, in_valid is ignored. Upstream holds in_data; no sample is lost or double-counted.
- clear:
  - clear=1 in any state on an edge: acc=0, frame_cnt=0, out_valid=0, state=S_ACC.
  - A pending output is discarded.
  - clear has priority over a simultaneous accept; that sample is dropped. in_ready stays 1 in S_ACC during clear, so upstream sees the drop.
- rst has priority over clear.
- frame_cnt wraps N-1 to 0 exactly at frame completion. It never reaches N.

Test Plan:
- N=4, out_ready=1, in_valid=1. Samples (re,im) = (4,1),(1,2),(-3,5),(6,0) -> one cycle after 4th accept, out_valid=1, out_data=0x0002_0002, frame_cnt=0.
- Samples 4x (-1,-3) -> out_data=0xFFFF_FFFD. Samples (1,-1),(0,0),(0,0),(0,0) -> out_data=0x0000_FFFF (floor rounding).
- Extremes: 4x (0x7FFF,0x8000) -> out_data=0x7FFF_8000; no overflow.
- Backpressure: complete a frame with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0 and out_data stable all 5 cycles. Then out_ready=1 for 1 cycle -> handshake, next cycle in_ready=1, and the next sample is counted as the first of the new frame.
- clear mid-frame: accept (100,100),(100,100), pulse clear, then (2,2),(2,2),(2,2),(2,2) -> out_data=0x0002_0002. Also clear asserted during S_OUT -> out_valid=0 next cycle, frame_cnt=0.
- Reset mid-frame: accept 3 samples, assert rst 1 cycle -> out_valid=0, frame_cnt=0, out_data=0, in_ready=0 during rst. The next 4 samples alone determine the result.

Source files
------------

// File: rtl/cplx_result_avg.sv
// cplx_result_avg: frame averager for packed complex result words.
// Accumulates 2^LOG2_N samples {real[31:16], imag[15:0]} and emits the
// per-component floor average as one packed word on a valid/ready port.
module cplx_result_avg #(
  parameter int LOG2_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOG2_N-1:0] frame_cnt
);

  // Headroom of LOG2_N bits above the sample width makes overflow impossible.
  localparam int ACC_W = 16 + LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
  localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

  typedef enum logic [0:0] {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0]   acc_im_q, acc_im_d;
  logic        [LOG2_N-1:0]  cnt_q, cnt_d;
  logic        [31:0]        out_data_q, out_data_d;

  logic signed [ACC_W-1:0]   x_re_s, x_im_s;
  logic signed [ACC_W-1:0]   sum_re_s, sum_im_s;
  logic signed [ACC_W-1:0]   shr_re_s, shr_im_s;
  logic                      in_ready_s;
  logic                      accept_s;

  // Sign-extend the incoming halves and form the running sums and averages.
  always_comb begin
    x_re_s   = {{LOG2_N{in_data[31]}}, in_data[31:16]};
    x_im_s   = {{LOG2_N{in_data[15]}}, in_data[15:0]};
    sum_re_s = acc_re_q + x_re_s;
    sum_im_s = acc_im_q + x_im_s;
    shr_re_s = sum_re_s >>> LOG2_N;
    shr_im_s = sum_im_s >>> LOG2_N;
  end

  // in_ready is gated by rst so upstream never sees a ready during reset.
  assign in_ready_s = (state_q == S_ACC) && !rst;
  assign accept_s   = in_valid && in_ready_s;

  // Next-state logic: accumulate, emit on the last sample, clear overrides.
  always_comb begin
    state_d    = state_q;
    acc_re_d   = acc_re_q;
    acc_im_d   = acc_im_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;

    case (state_q)
      S_ACC: begin
        if (accept_s) begin
          if (cnt_q == CNT_LAST) begin
            out_data_d = {shr_re_s[15:0], shr_im_s[15:0]};
            acc_re_d   = '0;
            acc_im_d   = '0;
            cnt_d      = '0;
            state_d    = S_OUT;
          end else begin
            acc_re_d   = sum_re_s;
            acc_im_d   = sum_im_s;
            cnt_d      = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = S_ACC;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_ACC;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_ACC;
      end
    endcase

    // A frame abort drops partial sums, any pending output and a coincident sample.
    if (clear) begin
      acc_re_d   = '0;
      acc_im_d   = '0;
      cnt_d      = '0;
      out_data_d = out_data_q;
      state_d    = S_ACC;
    end else begin
      state_d    = state_d;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ACC;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      cnt_q      <= '0;
      out_data_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_cplx_result_avg.sv
// Directed self-checking bench for cplx_result_avg with N = 4.
module tb_cplx_result_avg;

  localparam int LOG2_N = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic              clear;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LOG2_N-1:0] frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  cplx_result_avg #(.LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until it is accepted (bounded wait).
  task automatic send(input logic [15:0] re, input logic [15:0] im);
    int t = 0;
    in_data  = {re, im};
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Send four identical samples.
  task automatic send4(input logic [15:0] re, input logic [15:0] im);
    for (int i = 0; i < 4; i++) send(re, im);
  endtask

  // Check the result cycle right after the last accept of a frame.
  task automatic chk_result(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  out_data,       exp);
    chk({tag, "_cnt"},   32'(frame_cnt), 32'd0);
  endtask

  // Complete the output handshake and confirm return to accumulation.
  task automatic ack(input string tag);
    out_ready = 1'b1;
    step();
    chk({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ack_ready"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_data   = 32'h0000_0000;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,       32'h0000_0000);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Mixed positive/negative samples: sums (8,8) -> (2,2).
    send(16'd4, 16'd1);
    send(16'd1, 16'd2);
    chk("mix_cnt2", 32'(frame_cnt), 32'd2);
    chk("mix_mid_valid", 32'(out_valid), 32'd0);
    send(-16'sd3, 16'd5);
    send(16'd6, 16'd0);
    chk_result("mix", 32'h0002_0002);
    ack("mix");

    // All negative: sums (-4,-12) -> (-1,-3).
    send4(16'hFFFF, 16'hFFFD);
    chk_result("neg", 32'hFFFF_FFFD);
    ack("neg");

    // Floor rounding: sums (1,-1) -> (0,-1).
    send(16'd1, 16'hFFFF);
    send(16'd0, 16'd0);
    send(16'd0, 16'd0);
    send(16'd0, 16'd0);
    chk_result("floor", 32'h0000_FFFF);
    ack("floor");

    // Extremes: no overflow in the accumulator.
    send4(16'h7FFF, 16'h8000);
    chk_result("ext", 32'h7FFF_8000);
    ack("ext");

    // Backpressure: output held for 5 cycles while upstream keeps offering.
    out_ready = 1'b0;
    send4(16'd8, 16'd4);
    in_data  = {16'd9, 16'd9};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_data",  out_data,       32'h0008_0004);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_hs_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_ready", 32'(in_ready),  32'd1);
    chk("bp_hs_cnt",   32'(frame_cnt), 32'd0);
    step();
    in_valid = 1'b0;
    chk("bp_first_cnt", 32'(frame_cnt), 32'd1);
    send(16'd1, 16'd1);
    send(16'd1, 16'd1);
    send(16'd1, 16'd1);
    chk_result("bp_next", 32'h0003_0003);
    ack("bp_next");

    // Clear mid-frame, with a coincident offered sample that must be dropped.
    send(16'd100, 16'd100);
    send(16'd100, 16'd100);
    chk("clr_cnt2", 32'(frame_cnt), 32'd2);
    clear    = 1'b1;
    in_data  = {16'd50, 16'd50};
    in_valid = 1'b1;
    #1;
    chk("clr_ready_during", 32'(in_ready), 32'd1);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_cnt0", 32'(frame_cnt), 32'd0);
    send4(16'd2, 16'd2);
    chk_result("clr", 32'h0002_0002);
    ack("clr");

    // Clear during the output state discards the pending result.
    out_ready = 1'b0;
    send4(16'd5, 16'd5);
    chk_result("clr_out", 32'h0005_0005);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_out_cnt",   32'(frame_cnt), 32'd0);
    chk("clr_out_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;

    // Reset mid-frame drops partial sums and the old output word.
    send(16'd100, 16'd100);
    send(16'd100, 16'd100);
    send(16'd100, 16'd100);
    rst = 1'b1;
    #1;
    chk("mrst_ready_high", 32'(in_ready), 32'd0);
    step();
    chk("mrst_ready", 32'(in_ready),  32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_cnt",   32'(frame_cnt), 32'd0);
    chk("mrst_data",  out_data,       32'h0000_0000);
    rst = 1'b0;
    #1;
    chk("mrst_ready_after", 32'(in_ready), 32'd1);
    send4(16'hFFFC, 16'd8);
    chk_result("mrst", 32'hFFFC_0008);
    ack("mrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
